merlin_mem_arb: RTL and testbench

- Shares one memory request/response port between the prefetch unit's instruction port and the load/store data port.
- Lets the merlin32i core sit on a single unified memory bus.
- Arbitrates requests with data priority and a starvation guard for instruction fetches.
- Records the owner of each accepted request in an in-order outstanding FIFO, and routes each memory response back to its owner.

---
 rtl/merlin_mem_pkg.sv | 22 ++
 rtl/merlin_ostd_fifo.sv | 58 +++++
 rtl/merlin_mem_arb.sv | 160 ++++++++++++++++
 tb/tb_merlin_mem_arb.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/merlin_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | merlin_mem_pkg : shared types for the merlin unified memory arbiter      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package merlin_mem_pkg;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_t;

  localparam logic [3:0] C_IFETCH_BE = 4'hF;

endpackage
`default_nettype wire

// File: rtl/merlin_ostd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | merlin_ostd_fifo : 1-bit synchronous FIFO tracking outstanding owners    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module merlin_ostd_fifo #(
  parameter int DEPTH_X = 2
) (
  input  logic clk_i,
  input  logic resetb_i,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_din,
  output logic o_full,
  output logic o_empty,
  output logic o_head
);

  localparam int              c_depth    = 2 ** DEPTH_X;
  localparam logic [DEPTH_X:0] c_full_cnt = {1'b1, {DEPTH_X{1'b0}}};

  logic [c_depth-1:0] r_mem;
  logic [DEPTH_X-1:0] r_wr_ptr;
  logic [DEPTH_X-1:0] r_rd_ptr;
  logic [DEPTH_X:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == c_full_cnt);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/merlin_mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | merlin_mem_arb : instruction/data arbiter onto one memory port with     |
// |                  in-order response routing                               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module merlin_mem_arb
  import merlin_mem_pkg::*;
#(
  parameter int C_OSTD_DEPTH_X = 2,
  parameter int C_STARVE_MAX   = 3
) (
  input  logic        clk_i,
  input  logic        clk_en_i,
  input  logic        resetb_i,
  output logic        ireqready_o,
  input  logic        ireqvalid_i,
  input  logic [1:0]  ireqhpl_i,
  input  logic [31:0] ireqaddr_i,
  input  logic        irspready_i,
  output logic        irspvalid_o,
  output logic        irsprerr_o,
  output logic [31:0] irspdata_o,
  output logic        dreqready_o,
  input  logic        dreqvalid_i,
  input  logic [1:0]  dreqhpl_i,
  input  logic [31:0] dreqaddr_i,
  input  logic        dreqwr_i,
  input  logic [3:0]  dreqbe_i,
  input  logic [31:0] dreqdata_i,
  input  logic        drspready_i,
  output logic        drspvalid_o,
  output logic        drsprerr_o,
  output logic        drspwerr_o,
  output logic [31:0] drspdata_o,
  input  logic        mreqready_i,
  output logic        mreqvalid_o,
  output logic [1:0]  mreqhpl_o,
  output logic [31:0] mreqaddr_o,
  output logic        mreqwr_o,
  output logic [3:0]  mreqbe_o,
  output logic [31:0] mreqdata_o,
  output logic        mrspready_o,
  input  logic        mrspvalid_i,
  input  logic        mrsprerr_i,
  input  logic        mrspwerr_i,
  input  logic [31:0] mrspdata_i
);

  localparam logic [3:0] c_starve_max = 4'(C_STARVE_MAX);

  logic       r_live;
  arb_state_t r_state;
  logic [3:0] r_starve;

  logic w_full;
  logic w_empty;
  logic w_head;
  logic w_head_d;
  logic w_starved;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_gnt_valid;
  logic w_req_ok;
  logic w_req_xfer;
  logic w_rsp_pop;
  logic w_sel_i;
  logic w_sel_d;

  assign w_starved = (r_starve == c_starve_max);

  // Hold states lock the grant so the memory sees a stable request until it is taken.
  always_comb begin
    w_gnt_i = 1'b0;
    w_gnt_d = 1'b0;
    case (r_state)
      ARB_HOLD_I: w_gnt_i = 1'b1;
      ARB_HOLD_D: w_gnt_d = 1'b1;
      default: begin
        if (dreqvalid_i && !(w_starved && ireqvalid_i)) begin
          w_gnt_d = 1'b1;
        end else if (ireqvalid_i) begin
          w_gnt_i = 1'b1;
        end
      end
    endcase
  end

  assign w_gnt_valid = (w_gnt_i & ireqvalid_i) | (w_gnt_d & dreqvalid_i);
  assign w_req_ok    = r_live & ~w_full;
  assign mreqvalid_o = w_req_ok & w_gnt_valid;
  assign ireqready_o = mreqready_i & w_gnt_i & w_req_ok;
  assign dreqready_o = mreqready_i & w_gnt_d & w_req_ok;
  assign w_req_xfer  = mreqvalid_o & mreqready_i & clk_en_i;

  assign mreqhpl_o  = w_gnt_d ? dreqhpl_i  : ireqhpl_i;
  assign mreqaddr_o = w_gnt_d ? dreqaddr_i : ireqaddr_i;
  assign mreqwr_o   = w_gnt_d & dreqwr_i;
  assign mreqbe_o   = w_gnt_d ? dreqbe_i   : C_IFETCH_BE;
  assign mreqdata_o = w_gnt_d ? dreqdata_i : '0;

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_live   <= 1'b0;
      r_state  <= ARB_IDLE;
      r_starve <= '0;
    end else if (clk_en_i) begin
      r_live <= 1'b1;
      case (r_state)
        ARB_IDLE: begin
          if (mreqvalid_o && !mreqready_i) begin
            r_state <= w_gnt_d ? ARB_HOLD_D : ARB_HOLD_I;
          end
        end
        ARB_HOLD_I: begin
          if (!ireqvalid_i || w_req_xfer) r_state <= ARB_IDLE;
        end
        ARB_HOLD_D: begin
          if (!dreqvalid_i || w_req_xfer) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
      if (!ireqvalid_i || (w_req_xfer && w_gnt_i)) begin
        r_starve <= '0;
      end else if (w_req_xfer && w_gnt_d && !w_starved) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

  merlin_ostd_fifo #(
    .DEPTH_X (C_OSTD_DEPTH_X)
  ) u_ostd_fifo (
    .clk_i    (clk_i),
    .resetb_i (resetb_i),
    .i_push   (w_req_xfer),
    .i_pop    (w_rsp_pop),
    .i_din    (w_gnt_d),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_head   (w_head)
  );

  // An empty FIFO still accepts responses so stray ones are drained and dropped.
  assign w_head_d    = (w_head == OWNER_D);
  assign w_sel_i     = r_live & ~w_empty & ~w_head_d;
  assign w_sel_d     = r_live & ~w_empty & w_head_d;
  assign mrspready_o = r_live & (w_empty | (w_head_d ? drspready_i : irspready_i));
  assign w_rsp_pop   = mrspvalid_i & mrspready_o & clk_en_i & ~w_empty;

  assign irspvalid_o = mrspvalid_i & w_sel_i;
  assign drspvalid_o = mrspvalid_i & w_sel_d;
  assign irsprerr_o  = r_live & mrsprerr_i;
  assign drsprerr_o  = r_live & mrsprerr_i;
  assign drspwerr_o  = r_live & mrspwerr_i;
  assign irspdata_o  = w_sel_i ? mrspdata_i : '0;
  assign drspdata_o  = w_sel_d ? mrspdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_merlin_mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_merlin_mem_arb : directed plus random bench against a queue model     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_merlin_mem_arb;

  localparam int DEPTH  = 4;
  localparam int STARVE = 3;

  logic        clk_i = 1'b0;
  logic        clk_en_i = 1'b1;
  logic        resetb_i = 1'b0;
  logic        ireqready_o, ireqvalid_i = 1'b0;
  logic [1:0]  ireqhpl_i = '0;
  logic [31:0] ireqaddr_i = '0;
  logic        irspready_i = 1'b1, irspvalid_o, irsprerr_o;
  logic [31:0] irspdata_o;
  logic        dreqready_o, dreqvalid_i = 1'b0;
  logic [1:0]  dreqhpl_i = '0;
  logic [31:0] dreqaddr_i = '0;
  logic        dreqwr_i = 1'b0;
  logic [3:0]  dreqbe_i = '0;
  logic [31:0] dreqdata_i = '0;
  logic        drspready_i = 1'b1, drspvalid_o, drsprerr_o, drspwerr_o;
  logic [31:0] drspdata_o;
  logic        mreqready_i = 1'b0, mreqvalid_o;
  logic [1:0]  mreqhpl_o;
  logic [31:0] mreqaddr_o;
  logic        mreqwr_o;
  logic [3:0]  mreqbe_o;
  logic [31:0] mreqdata_o;
  logic        mrspready_o, mrspvalid_i = 1'b0, mrsprerr_i = 1'b0, mrspwerr_i = 1'b0;
  logic [31:0] mrspdata_i = '0;

  merlin_mem_arb #(.C_OSTD_DEPTH_X(2), .C_STARVE_MAX(STARVE)) dut (
    .clk_i(clk_i), .clk_en_i(clk_en_i), .resetb_i(resetb_i),
    .ireqready_o(ireqready_o), .ireqvalid_i(ireqvalid_i), .ireqhpl_i(ireqhpl_i),
    .ireqaddr_i(ireqaddr_i), .irspready_i(irspready_i), .irspvalid_o(irspvalid_o),
    .irsprerr_o(irsprerr_o), .irspdata_o(irspdata_o),
    .dreqready_o(dreqready_o), .dreqvalid_i(dreqvalid_i), .dreqhpl_i(dreqhpl_i),
    .dreqaddr_i(dreqaddr_i), .dreqwr_i(dreqwr_i), .dreqbe_i(dreqbe_i),
    .dreqdata_i(dreqdata_i), .drspready_i(drspready_i), .drspvalid_o(drspvalid_o),
    .drsprerr_o(drsprerr_o), .drspwerr_o(drspwerr_o), .drspdata_o(drspdata_o),
    .mreqready_i(mreqready_i), .mreqvalid_o(mreqvalid_o), .mreqhpl_o(mreqhpl_o),
    .mreqaddr_o(mreqaddr_o), .mreqwr_o(mreqwr_o), .mreqbe_o(mreqbe_o),
    .mreqdata_o(mreqdata_o), .mrspready_o(mrspready_o), .mrspvalid_i(mrspvalid_i),
    .mrsprerr_i(mrsprerr_i), .mrspwerr_i(mrspwerr_i), .mrspdata_i(mrspdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner queue (0 = I, 1 = D), locked owner, starvation count.
  int q_own[$];
  int m_lock   = 0;
  int m_starve = 0;
  bit m_live   = 1'b0;
  bit last_ix  = 1'b0;
  bit last_dx  = 1'b0;
  int n_igrant = 0;
  int n_dgrant = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_own.delete();
    m_lock = 0; m_starve = 0; m_live = 1'b0; last_ix = 1'b0; last_dx = 1'b0;
  endtask

  task automatic tick();
    int  g;
    bit  full, empty, head_d, ev, sel_i, sel_d, emrdy, rx, px;
    @(negedge clk_i);
    full   = (q_own.size() == DEPTH);
    empty  = (q_own.size() == 0);
    head_d = !empty && (q_own[0] == 1);
    if (m_lock != 0) g = m_lock;
    else if (dreqvalid_i && !(m_starve == STARVE && ireqvalid_i)) g = 2;
    else if (ireqvalid_i) g = 1;
    else g = 0;
    ev = m_live && !full && ((g == 1 && ireqvalid_i) || (g == 2 && dreqvalid_i));
    chk("mreqvalid", mreqvalid_o, ev);
    chk("ireqready", ireqready_o, m_live && mreqready_i && g == 1 && !full);
    chk("dreqready", dreqready_o, m_live && mreqready_i && g == 2 && !full);
    if (ev) begin
      chk("mreqaddr", mreqaddr_o, (g == 2) ? dreqaddr_i : ireqaddr_i);
      chk("mreqhpl",  mreqhpl_o,  (g == 2) ? dreqhpl_i  : ireqhpl_i);
      chk("mreqwr",   mreqwr_o,   (g == 2) ? dreqwr_i   : 1'b0);
      chk("mreqbe",   mreqbe_o,   (g == 2) ? dreqbe_i   : 4'hF);
      chk("mreqdata", mreqdata_o, (g == 2) ? dreqdata_i : 32'h0);
    end
    sel_i = m_live && !empty && !head_d;
    sel_d = m_live && !empty && head_d;
    emrdy = m_live && (empty || (head_d ? drspready_i : irspready_i));
    chk("mrspready", mrspready_o, emrdy);
    chk("irspvalid", irspvalid_o, sel_i && mrspvalid_i);
    chk("drspvalid", drspvalid_o, sel_d && mrspvalid_i);
    chk("irspdata",  irspdata_o,  sel_i ? mrspdata_i : 32'h0);
    chk("drspdata",  drspdata_o,  sel_d ? mrspdata_i : 32'h0);
    chk("irsprerr",  irsprerr_o,  m_live && mrsprerr_i);
    chk("drsprerr",  drsprerr_o,  m_live && mrsprerr_i);
    chk("drspwerr",  drspwerr_o,  m_live && mrspwerr_i);
    rx = ev && mreqready_i && clk_en_i;
    px = mrspvalid_i && emrdy && clk_en_i && !empty;
    @(posedge clk_i);
    #1;
    if (clk_en_i) begin
      if (px) void'(q_own.pop_front());
      if (rx) q_own.push_back((g == 2) ? 1 : 0);
      if (!ireqvalid_i || (rx && g == 1)) m_starve = 0;
      else if (rx && g == 2 && m_starve < STARVE) m_starve++;
      if (m_lock == 0) begin
        if (ev && !mreqready_i) m_lock = g;
      end else if (rx || !((m_lock == 1) ? ireqvalid_i : dreqvalid_i)) begin
        m_lock = 0;
      end
      m_live = 1'b1;
    end
    last_ix = rx && g == 1;
    last_dx = rx && g == 2;
    if (last_ix) n_igrant++;
    if (last_dx) n_dgrant++;
  endtask

  task automatic do_reset();
    resetb_i = 1'b0;
    #1;
    chk("rst_mreqvalid", mreqvalid_o, 1'b0);
    chk("rst_ireqready", ireqready_o, 1'b0);
    chk("rst_dreqready", dreqready_o, 1'b0);
    chk("rst_mrspready", mrspready_o, 1'b0);
    chk("rst_irspvalid", irspvalid_o, 1'b0);
    chk("rst_drspvalid", drspvalid_o, 1'b0);
    chk("rst_drspdata",  drspdata_o,  32'h0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    resetb_i = 1'b1;
  endtask

  task automatic idle_inputs();
    ireqvalid_i = 1'b0; dreqvalid_i = 1'b0; mrspvalid_i = 1'b0;
    mreqready_i = 1'b1; irspready_i = 1'b1; drspready_i = 1'b1; clk_en_i = 1'b1;
  endtask

  task automatic drain();
    idle_inputs();
    mrspvalid_i = 1'b1;
    for (int k = 0; k < 10 && q_own.size() > 0; k++) tick();
    mrspvalid_i = 1'b0;
  endtask

  initial begin
    #2;
    idle_inputs();
    mrspvalid_i = 1'b1;
    do_reset();
    tick();                              // live=0 cycle, stray response ignored
    mrspvalid_i = 1'b0;

    // Both requesters at once: data wins, instruction follows
    ireqvalid_i = 1'b1; ireqaddr_i = 32'h100; ireqhpl_i = 2'd3;
    dreqvalid_i = 1'b1; dreqaddr_i = 32'h200; dreqwr_i = 1'b1;
    dreqbe_i = 4'h3; dreqdata_i = 32'hCAFE0001; dreqhpl_i = 2'd1;
    tick();
    dreqvalid_i = 1'b0;
    tick();
    ireqvalid_i = 1'b0;
    chk("first_two_owners", (q_own.size() == 2) ? {mrspready_o, 31'h0} : 32'h1, 32'h8000_0000);

    // Continuous data with a waiting fetch: one fetch every STARVE+1 transfers
    n_igrant = 0; n_dgrant = 0;
    ireqvalid_i = 1'b1; ireqaddr_i = 32'h1000;
    dreqvalid_i = 1'b1; dreqwr_i = 1'b0;
    mrspvalid_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      dreqaddr_i = 32'h2000 + 32'(k * 4);
      if (last_ix) ireqaddr_i = ireqaddr_i + 32'h4;
      mrspdata_i = $urandom;
      tick();
    end
    chk("starve_igrants", 32'(n_igrant), 32'd2);
    chk("starve_dgrants", 32'(n_dgrant), 32'd6);
    drain();

    // Held instruction grant survives a later data request
    ireqvalid_i = 1'b1; ireqaddr_i = 32'h300; mreqready_i = 1'b0;
    tick();
    tick();
    dreqvalid_i = 1'b1; dreqaddr_i = 32'h400; dreqwr_i = 1'b0;
    repeat (3) tick();
    chk("hold_addr", mreqaddr_o, 32'h300);
    mreqready_i = 1'b1;
    tick();
    ireqvalid_i = 1'b0;
    tick();
    dreqvalid_i = 1'b0;
    drain();

    // Fill the outstanding FIFO, then free one slot
    dreqvalid_i = 1'b1; dreqwr_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      dreqaddr_i = 32'h5000 + 32'(k * 4);
      if (last_dx || k == 0) dreqdata_i = $urandom;
      tick();
    end
    chk("full_block", mreqvalid_o, 1'b0);
    mrspvalid_i = 1'b1; mrspwerr_i = 1'b1;
    tick();
    mrspvalid_i = 1'b0; mrspwerr_i = 1'b0;
    tick();
    dreqvalid_i = 1'b0;
    drain();

    // Instruction response stalled by its sink, data sink untouched
    ireqvalid_i = 1'b1; ireqaddr_i = 32'h600;
    tick();
    ireqvalid_i = 1'b0; dreqvalid_i = 1'b1; dreqaddr_i = 32'h700; dreqwr_i = 1'b0;
    tick();
    dreqvalid_i = 1'b0;
    mrspvalid_i = 1'b1; mrspdata_i = 32'hDEADBEEF; irspready_i = 1'b0; mrsprerr_i = 1'b1;
    repeat (3) tick();
    irspready_i = 1'b1;
    tick();
    mrspdata_i = 32'h12345678; mrsprerr_i = 1'b0;
    tick();

    // Unsolicited response, then reset with requests outstanding
    mrspdata_i = 32'hBAD0BAD0;
    tick();
    mrspvalid_i = 1'b0;
    ireqvalid_i = 1'b1; ireqaddr_i = 32'h800;
    dreqvalid_i = 1'b1; dreqaddr_i = 32'h900;
    tick();
    dreqvalid_i = 1'b0;
    tick();
    ireqvalid_i = 1'b0;
    mrspvalid_i = 1'b1;
    do_reset();
    repeat (3) tick();

    // Randomised traffic under the same model
    mrspvalid_i = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!ireqvalid_i || last_ix) begin
        ireqvalid_i = ($urandom_range(0, 2) != 0);
        ireqaddr_i  = $urandom;
        ireqhpl_i   = 2'($urandom);
      end
      if (!dreqvalid_i || last_dx) begin
        dreqvalid_i = ($urandom_range(0, 2) != 0);
        dreqaddr_i  = $urandom;
        dreqhpl_i   = 2'($urandom);
        dreqwr_i    = 1'($urandom);
        dreqbe_i    = 4'($urandom);
        dreqdata_i  = $urandom;
      end
      mreqready_i = ($urandom_range(0, 3) != 0);
      clk_en_i    = ($urandom_range(0, 7) != 0);
      mrspvalid_i = 1'($urandom);
      mrsprerr_i  = 1'($urandom);
      mrspwerr_i  = 1'($urandom);
      mrspdata_i  = $urandom;
      irspready_i = ($urandom_range(0, 3) != 0);
      drspready_i = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
